// File: rtl/piso_pkg.sv
// ----------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the serial link: piso_tx (transmit end) and the
// matching shift-left SIPO receiver.
//   state_t    : frame state of the transmitter (IDLE, SHIFT)
//   cnt_width  : bit-counter width for a WIDTH-bit word, clog2(WIDTH+1), wide
//                enough to hold WIDTH itself so the count never wraps even
//                when a trailing parity bit is sent.
// ----------------------------------------------------------------------------
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_tx.sv
// ----------------------------------------------------------------------------
// piso_tx
// Parallel-in/serial-out transmitter. A WIDTH-bit word is accepted through a
// valid/ready load handshake and shifted out MSB-first, one bit per shift_en
// strobe. The receiving SIPO register is clocked by the same shift_en and
// samples dout on the same clk edge as each strobe.
//
// Optional feature (macro PISO_TX_PARITY_EN): an even-parity bit (XOR of the
// loaded word) is appended after the data bits, making the frame WIDTH+1 bits.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   din        in   [WIDTH-1:0] parallel word to transmit
//   load_valid in   din is valid this cycle
//   load_ready out  transmitter can accept a word (IDLE)
//   shift_en   in   bit-rate strobe, shared with the receiver
//   dout       out  serial data bit, straight from the shift-register MSB flop
//   busy       out  frame in progress; dout meaningful only while high
//   done       out  one-cycle pulse after the last bit's strobe
// ----------------------------------------------------------------------------
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             dout,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

`ifdef PISO_TX_PARITY_EN
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             fill;

`ifdef PISO_TX_PARITY_EN
    logic par_q, par_d;
    // The parity flop is shifted in at the LSB; the first bit shifted in
    // reaches the MSB after exactly WIDTH strobes, i.e. when count==WIDTH.
    assign fill = par_q;
`else
    assign fill = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef PISO_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                // A load wins over a simultaneous strobe; the strobe is not counted.
                if (load_valid) begin
                    sr_d    = din;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef PISO_TX_PARITY_EN
                    par_d   = ^din;
`endif
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (cnt_q == LAST) begin
                        // Clearing the register keeps dout low while IDLE.
                        state_d = IDLE;
                        sr_d    = '0;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        sr_d  = {sr_q[WIDTH-2:0], fill};
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef PISO_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q == SHIFT);
    assign dout       = sr_q[WIDTH-1];
    assign done       = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// ----------------------------------------------------------------------------
// tb_piso_tx
// Scoreboard bench for piso_tx (WIDTH=4). Each accepted load pushes its
// expected serial bits into exp_q; a monitor pops one entry on every strobe
// taken while busy and compares it with dout. A behavioural shift-left SIPO
// receiver sits on the same strobe. Honours PISO_TX_PARITY_EN.
// ----------------------------------------------------------------------------
module tb_piso_tx;

    localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] din = '0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic         shift_en = 1'b0;
    logic         dout;
    logic         busy;
    logic         done;

    logic [W-1:0] rx_q = '0;
    logic         exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           done_cnt = 0;

    piso_tx #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .shift_en   (shift_en),
        .dout       (dout),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Paired receiver: shift-left SIPO on the same strobe and edge.
    always @(posedge clk) begin
        if (shift_en) rx_q <= {rx_q[W-2:0], dout};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the bit consumed by a strobe is the dout present before its edge.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (shift_en && busy && reset) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bit", 32'(dout), 32'hx);
            end else begin
                logic b;
                b = exp_q.pop_front();
                chk("serial_bit", 32'(dout), 32'(b));
            end
        end
    end

    task automatic push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef PISO_TX_PARITY_EN
        exp_q.push_back(^w);
`endif
    endtask

    task automatic load_word(input logic [W-1:0] w);
        din = w;
        load_valid = 1'b1;
        push_word(w);
        @(posedge clk); #1;
        load_valid = 1'b0;
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_ready_low", 32'(load_ready), 32'd0);
        chk("first_bit", 32'(dout), 32'(w[W-1]));
    endtask

    task automatic run_frame(input int gap);
        for (int k = 0; k < NB; k++) begin
            shift_en = 1'b1;
            @(posedge clk); #1;
            shift_en = 1'b0;
            if (k == NB - 1) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("end_busy", 32'(busy), 32'd0);
                chk("end_ready", 32'(load_ready), 32'd1);
                chk("idle_dout", 32'(dout), 32'd0);
            end else begin
                chk("mid_done", 32'(done), 32'd0);
                chk("mid_ready", 32'(load_ready), 32'd0);
                for (int g = 0; g < gap; g++) begin
                    logic held;
                    held = dout;
                    @(posedge clk); #1;
                    chk("gap_busy", 32'(busy), 32'd1);
                    chk("gap_done", 32'(done), 32'd0);
                    chk("gap_dout_stable", 32'(dout), 32'(held));
                end
            end
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        chk("done_drop", 32'(done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dc;
        logic [W-1:0] rx_exp;

        // Reset state
        #2;
        chk("rst_ready", 32'(load_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Basic frame 1011
        load_word(4'b1011);
        run_frame(0);
`ifdef PISO_TX_PARITY_EN
        rx_exp = {3'b011, 1'b1};
`else
        rx_exp = 4'b1011;
`endif
        chk("rx_word", 32'(rx_q), 32'(rx_exp));
        idle_cycle();

        // Sparse strobes, every 3rd cycle
        load_word(4'hA);
        run_frame(2);
        idle_cycle();

        // Handshake: load_valid stays high with a new word during the frame
        load_word(4'hA);
        din = 4'h5;
        load_valid = 1'b1;
        run_frame(0);
        @(posedge clk); #1;
        push_word(4'h5);
        load_valid = 1'b0;
        chk("back2back_busy", 32'(busy), 32'd1);
        chk("back2back_bit", 32'(dout), 32'd0);
        run_frame(0);
        idle_cycle();

        // Reset mid-frame after 2 bits
        load_word(4'hC);
        shift_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        shift_en = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort_dout", 32'(dout), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(load_ready), 32'd1);
        exp_q.delete();
        dc = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_no_done", 32'(done_cnt), 32'(dc));
        load_word(4'h6);
        run_frame(0);
        idle_cycle();

        // Load and strobe together in IDLE
        din = 4'b0001;
        load_valid = 1'b1;
        shift_en = 1'b1;
        push_word(4'b0001);
        @(posedge clk); #1;
        load_valid = 1'b0;
        shift_en = 1'b0;
        chk("sim_busy", 32'(busy), 32'd1);
        chk("sim_first_bit", 32'(dout), 32'd0);
        run_frame(0);
        idle_cycle();

        // Parity-oriented words (plain frames when parity is off)
        load_word(4'b0111);
        run_frame(0);
        idle_cycle();
        load_word(4'b0011);
        run_frame(0);
        idle_cycle();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in/serial-out transmitter. Accepts a WIDTH-bit word via a valid/ready load handshake and shifts it out MSB-first, one bit per shift_en strobe.
- Forms the transmit end of the serial link whose receive end is the team's shift-left SIPO register, clocked by the same shift_en.
- After WIDTH strobes, that SIPO register's parallel output equals the loaded word.
- Sits between the parallel datapath and the serial bit line.

Parameters:
- WIDTH, 4, data word width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word to transmit.
- load_valid  input  1  din is valid this cycle.
- load_ready  output  1  transmitter can accept a word.
- shift_en  input  1  bit-rate strobe; same signal that drives the receiver's shift_en.
- dout  output  1  serial data bit.
- busy  output  1  frame in progress; dout is meaningful only while high.
- done  output  1  one-cycle pulse after the last bit's strobe.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, shift register=0, bit count=0, stored parity=0.
  - Outputs: load_ready=1, busy=0, dout=0, done=0.
  - Reset asserted mid-frame aborts the frame immediately; no done pulse is generated.
- State IDLE:
  - load_ready=1, busy=0, dout=0. shift_en is ignored.
  - load_valid=1 at a rising edge: capture din into the shift register, clear count, go to SHIFT.
- State SHIFT:
  - load_ready=0, busy=1. load_valid is ignored and the in-flight word is never overwritten.
  - dout = shift register MSB, driven directly from a flop; no combinational path from din.
  - Bit k (k=0 first) is presented while count==k, so dout holds din[WIDTH-1-k] until the strobe that consumes it.
  - Each edge with shift_en=1: shift register <<= 1, count += 1.
  - Each edge with shift_en=0: all state held; strobes may be arbitrarily sparse.
  - Edge with shift_en=1 and count==LAST: go to IDLE, assert done for exactly the next cycle.
  - LAST = WIDTH-1 without the optional feature.
- Latency:
  - First bit appears on dout the cycle after the accepted load.
  - A frame takes exactly WIDTH strobes.
  - Minimum gap between frames is one IDLE cycle, so the next load is accepted in the cycle done is high.
- Boundary conditions:
  - load_valid and shift_en high together in IDLE: the load wins and the strobe is not counted.
  - The counter never wraps; its width is clog2(WIDTH+1).
- Receiver contract: the receiver samples dout on the same clk edge as each shift_en strobe.

Optional Feature:
- Macro: PISO_TX_PARITY_EN.
- Defined:
  - At load, store the XOR-reduction of din (even parity).
  - After the WIDTH data bits, one extra bit equal to the stored parity is presented; LAST = WIDTH.
  - done follows the (WIDTH+1)th strobe; busy stays high through the parity bit.
- Undefined: no parity logic, no parity flop, frame is WIDTH bits.

Decomposition:
- Shared package piso_pkg:
  - state typedef (IDLE, SHIFT).
  - function or constant for the counter width (clog2(WIDTH+1)).
  - The same package serves the matching receiver.
- No sub-module: the FSM, counter and shifter are a single register group, and parity is one reduction XOR.

Test Plan (WIDTH=4):
- Basic frame: load din=4'b1011, then 4 consecutive strobes -> dout sequence 1,0,1,1; done pulses once after the 4th strobe; paired SIPO receiver Q==4'b1011.
- Sparse strobes: din=4'hA with shift_en high every 3rd cycle -> dout is stable between strobes; done appears only after the 4th strobe; busy is high throughout.
- Handshake: load_valid held high during a frame with din changing to 4'h5 -> load_ready=0 and the frame still sends 4'hA; the next word 4'h5 is accepted in the done cycle.
- Reset mid-frame: assert reset after 2 of 4 bits -> same-cycle dout=0, busy=0, load_ready=1; no done pulse; after release, a new load sends a clean frame.
- Simultaneous load and strobe in IDLE: load 4'b0001 with shift_en=1 in the same cycle -> the strobe is ignored; the full 4-bit frame 0,0,0,1 follows.
- PISO_TX_PARITY_EN defined: din=4'b0111 -> dout 0,1,1,1 then parity bit 1; done after the 5th strobe. din=4'b0011 -> parity bit 0.
